// File: rtl/pwm_cfg_sched.sv
// pwm_cfg_sched: configuration and sequencing controller for a PWM period
// counter. Host writes land in shadow registers; shadows are committed to the
// active AAR/CCR/mode/RCR only at period boundaries (after RCR+1 periods), so
// a period never runs on a half-updated configuration.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cfg_we/addr/wdata shadow write port (0=AAR, 1=CCR, 2=CTRL bit0 mode, 3=RCR)
//   cfg_rdata         combinational shadow readback, zero-extended
//   start, stop       start request / graceful stop request
//   cnt_val           current counter value
//   PWM_EN            counter enable
//   mode, AAR, CCR    active configuration seen by the counter/compare stage
//   upd_irq           one-cycle pulse after a boundary commit
//   busy              high while running or waiting for the stop boundary
module pwm_cfg_sched #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned RCR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cfg_rdata,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             PWM_EN,
  output logic             mode,
  output logic [WIDTH-1:0] AAR,
  output logic [WIDTH-1:0] CCR,
  output logic             upd_irq,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_STOP_PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aar_sh, ccr_sh, prev_cnt;
  logic             mode_sh;
  logic [RCR_W-1:0] rcr_sh, rcr_q, rep_cnt;
  logic             pb_c, ue_c, commit_c, rep_clr_c, irq_d;

  // Period boundary: end of count in up mode, return to zero in up-down mode.
  // prev_cnt is cleared while disabled so the initial zero after start is not
  // mistaken for a return to zero.
  always_comb begin
    pb_c = 1'b0;
    if (PWM_EN) begin
      if (!mode) pb_c = (cnt_val >= AAR);
      else       pb_c = (cnt_val == '0) && (prev_cnt != '0);
    end
  end

  assign ue_c = pb_c && (rep_cnt == rcr_q);

  // Next-state and sequencing decisions
  always_comb begin
    state_d   = state_q;
    commit_c  = 1'b0;
    rep_clr_c = 1'b0;
    irq_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_RUN;
          commit_c  = 1'b1;
          rep_clr_c = 1'b1;
        end
      end
      S_RUN: begin
        if (ue_c) begin
          commit_c = 1'b1;
          irq_d    = 1'b1;
        end
        if (stop) state_d = S_STOP_PEND;
      end
      S_STOP_PEND: begin
        if (ue_c) begin
          commit_c = 1'b1;
          irq_d    = 1'b1;
        end
        // Stop at the first raw boundary regardless of repetition count
        if (pb_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      PWM_EN  <= 1'b0;
      busy    <= 1'b0;
      upd_irq <= 1'b0;
    end else begin
      state_q <= state_d;
      PWM_EN  <= (state_d != S_IDLE);
      busy    <= (state_d != S_IDLE);
      upd_irq <= irq_d;
    end
  end

  // Shadow, active configuration, repetition counter and previous count.
  // Commit reads the pre-write shadow, so a same-cycle write waits one commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      aar_sh   <= '0;
      ccr_sh   <= '0;
      mode_sh  <= 1'b0;
      rcr_sh   <= '0;
      AAR      <= '0;
      CCR      <= '0;
      mode     <= 1'b0;
      rcr_q    <= '0;
      rep_cnt  <= '0;
      prev_cnt <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: aar_sh  <= cfg_wdata;
          2'd1: ccr_sh  <= cfg_wdata;
          2'd2: mode_sh <= cfg_wdata[0];
          2'd3: rcr_sh  <= cfg_wdata[RCR_W-1:0];
          default: ;
        endcase
      end
      if (commit_c) begin
        AAR   <= aar_sh;
        CCR   <= ccr_sh;
        mode  <= mode_sh;
        rcr_q <= rcr_sh;
      end
      if (rep_clr_c || ue_c) rep_cnt <= '0;
      else if (pb_c)         rep_cnt <= rep_cnt + RCR_W'(1);
      prev_cnt <= PWM_EN ? cnt_val : '0;
    end
  end

  // Shadow readback
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0: cfg_rdata = aar_sh;
      2'd1: cfg_rdata = ccr_sh;
      2'd2: cfg_rdata = WIDTH'(mode_sh);
      2'd3: cfg_rdata = WIDTH'(rcr_sh);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pwm_cfg_sched.sv
// tb_pwm_cfg_sched: directed bench for pwm_cfg_sched with a behavioural
// up / up-down period counter closing the loop on PWM_EN, AAR and mode.
module tb_pwm_cfg_sched;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned RCR_W = 8;

  logic             clk = 1'b0;
  logic             rst, cfg_we, start, stop;
  logic [1:0]       cfg_addr;
  logic [WIDTH-1:0] cfg_wdata, cfg_rdata, AAR, CCR;
  logic [WIDTH-1:0] cnt_val = '0;
  logic             PWM_EN, mode, upd_irq, busy;
  logic             cnt_down = 1'b0;
  int               n_vec = 0;
  int               n_err = 0;
  int               n;
  int               ud_cnt [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int               ud_irq [8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  always #5 clk = ~clk;

  pwm_cfg_sched #(.WIDTH(WIDTH), .RCR_W(RCR_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .start(start), .stop(stop),
    .cnt_val(cnt_val), .PWM_EN(PWM_EN), .mode(mode), .AAR(AAR), .CCR(CCR),
    .upd_irq(upd_irq), .busy(busy)
  );

  // Period counter: clears while disabled, wraps at AAR (up) or bounces (up-down)
  always @(posedge clk) begin
    if (!PWM_EN) begin
      cnt_val  <= '0;
      cnt_down <= 1'b0;
    end else if (!mode) begin
      cnt_val <= (cnt_val >= AAR) ? '0 : cnt_val + WIDTH'(1);
    end else if (cnt_down) begin
      cnt_val <= cnt_val - WIDTH'(1);
      if (cnt_val == WIDTH'(1)) cnt_down <= 1'b0;
    end else if (cnt_val >= AAR) begin
      cnt_val  <= cnt_val - WIDTH'(1);
      cnt_down <= 1'b1;
    end else begin
      cnt_val <= cnt_val + WIDTH'(1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [WIDTH-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    cyc();
    cfg_we    = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [WIDTH-1:0] exp,
                        input string tag);
    cfg_addr = a;
    #1;
    check(tag, cfg_rdata, exp);
  endtask

  task automatic wait_cnt(input logic [WIDTH-1:0] v, input string tag);
    int k = 0;
    while (cnt_val !== v && k < 100) begin
      cyc();
      k++;
    end
    check(tag, WIDTH'(cnt_val === v), WIDTH'(1));
  endtask

  task automatic wait_irq(output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!upd_irq && cycles < 100);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      cyc();
      k++;
    end
    check(tag, WIDTH'(busy), WIDTH'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0;
    cyc(); cyc();
    check("rst_pwm_en", WIDTH'(PWM_EN), WIDTH'(0));
    check("rst_busy",   WIDTH'(busy),   WIDTH'(0));
    check("rst_irq",    WIDTH'(upd_irq), WIDTH'(0));
    check("rst_mode",   WIDTH'(mode),   WIDTH'(0));
    check("rst_aar",    AAR, WIDTH'(0));
    check("rst_ccr",    CCR, WIDTH'(0));
    rst = 1'b0;

    // Basic start: AAR=4, CCR=2, up mode, update every period
    wr(2'd0, WIDTH'(4)); wr(2'd1, WIDTH'(2)); wr(2'd2, WIDTH'(0)); wr(2'd3, WIDTH'(0));
    rd_chk(2'd0, WIDTH'(4), "rd_aar");
    rd_chk(2'd1, WIDTH'(2), "rd_ccr");
    check("aar_not_direct", AAR, WIDTH'(0));
    start = 1'b1; cyc(); start = 1'b0;
    check("start_pwm_en", WIDTH'(PWM_EN), WIDTH'(1));
    check("start_busy",   WIDTH'(busy),   WIDTH'(1));
    check("start_aar",    AAR, WIDTH'(4));
    check("start_ccr",    CCR, WIDTH'(2));
    check("start_no_irq", WIDTH'(upd_irq), WIDTH'(0));
    check("start_cnt0",   cnt_val, WIDTH'(0));
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("irq_mid_period", WIDTH'(upd_irq), WIDTH'(0));
    end
    cyc();
    check("irq_after_pb", WIDTH'(upd_irq), WIDTH'(1));
    check("cnt_wrapped",  cnt_val, WIDTH'(0));

    // Shadowing: write at cnt=1 commits at the cnt=4 boundary
    cyc();
    wr(2'd0, WIDTH'(9));
    check("aar_held", AAR, WIDTH'(4));
    wait_cnt(WIDTH'(4), "reach4");
    check("aar_held_pb", AAR, WIDTH'(4));
    cyc();
    check("aar_commit9", AAR, WIDTH'(9));
    check("irq_commit9", WIDTH'(upd_irq), WIDTH'(1));
    wait_cnt(WIDTH'(9), "reach9");
    // Write in the update cycle: active takes the pre-write value
    wr(2'd0, WIDTH'(3));
    check("aar_prewrite", AAR, WIDTH'(9));
    check("irq_prewrite", WIDTH'(upd_irq), WIDTH'(1));
    wait_cnt(WIDTH'(9), "reach9b");
    cyc();
    check("aar_late_commit", AAR, WIDTH'(3));

    // Repetition: RCR=2 with AAR=3 gives an update every 12 cycles
    wr(2'd3, 64'h1234_0000_0000_0002);
    rd_chk(2'd3, WIDTH'(2), "rd_rcr_trunc");
    wait_irq(n);
    check("rep_first_irq", WIDTH'(n), WIDTH'(3));
    wr(2'd0, WIDTH'(6));
    check("rep_aar_held", AAR, WIDTH'(3));
    wait_irq(n);
    check("rep_interval", WIDTH'(n), WIDTH'(11));
    check("rep_aar_commit", AAR, WIDTH'(6));

    // Stop, then reconfigure in IDLE
    stop = 1'b1; cyc(); stop = 1'b0;
    check("stop_pend_busy", WIDTH'(busy), WIDTH'(1));
    wait_idle("stop1_idle");
    check("stop1_pwm_en", WIDTH'(PWM_EN), WIDTH'(0));
    wr(2'd0, WIDTH'(5));
    wr(2'd3, 64'hFFFF_FFFF_FFFF_FF03);
    rd_chk(2'd3, WIDTH'(3), "rd_rcr_zext");
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check("start_stop_idle", WIDTH'(PWM_EN), WIDTH'(0));
    check("start_stop_aar",  AAR, WIDTH'(6));
    stop = 1'b1; cyc(); stop = 1'b0;
    check("stop_alone_idle", WIDTH'(busy), WIDTH'(0));

    // Graceful stop: AAR=5, RCR=3, stop at cnt=2
    start = 1'b1; cyc(); start = 1'b0;
    check("gs_aar", AAR, WIDTH'(5));
    check("gs_pwm_en", WIDTH'(PWM_EN), WIDTH'(1));
    wait_cnt(WIDTH'(2), "gs_reach2");
    stop = 1'b1; cyc(); stop = 1'b0;
    check("gs_busy_cnt3", WIDTH'(busy), WIDTH'(1));
    start = 1'b1; cyc(); start = 1'b0;
    check("gs_en_cnt4", WIDTH'(PWM_EN), WIDTH'(1));
    cyc();
    check("gs_en_cnt5", WIDTH'(PWM_EN), WIDTH'(1));
    check("gs_cnt5", cnt_val, WIDTH'(5));
    cyc();
    check("gs_en_off", WIDTH'(PWM_EN), WIDTH'(0));
    check("gs_busy_off", WIDTH'(busy), WIDTH'(0));
    check("gs_no_irq", WIDTH'(upd_irq), WIDTH'(0));

    // Up-down: AAR=3, boundary only on return to zero
    wr(2'd2, 64'hFFFF_FFFF_FFFF_FFF1);
    wr(2'd0, WIDTH'(3));
    wr(2'd3, WIDTH'(0));
    rd_chk(2'd2, WIDTH'(1), "rd_ctrl");
    start = 1'b1; cyc(); start = 1'b0;
    check("ud_mode", WIDTH'(mode), WIDTH'(1));
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      check("ud_cnt", cnt_val, WIDTH'(ud_cnt[i]));
      check("ud_irq", WIDTH'(upd_irq), WIDTH'(ud_irq[i]));
    end

    // Reset during STOP_PEND at cnt=3
    stop = 1'b1; cyc(); stop = 1'b0;
    check("ud_stop_pend", WIDTH'(busy), WIDTH'(1));
    wait_cnt(WIDTH'(3), "ud_reach3");
    rst = 1'b1; cyc(); rst = 1'b0;
    check("mrst_pwm_en", WIDTH'(PWM_EN), WIDTH'(0));
    check("mrst_busy",   WIDTH'(busy),   WIDTH'(0));
    check("mrst_mode",   WIDTH'(mode),   WIDTH'(0));
    check("mrst_aar",    AAR, WIDTH'(0));
    check("mrst_ccr",    CCR, WIDTH'(0));
    for (int a = 0; a < 4; a++) rd_chk(2'(a), WIDTH'(0), "mrst_rdata");

    // AAR=0 in up mode: boundary every cycle
    start = 1'b1; cyc(); start = 1'b0;
    check("aar0_first", WIDTH'(upd_irq), WIDTH'(0));
    cyc();
    check("aar0_irq1", WIDTH'(upd_irq), WIDTH'(1));
    cyc();
    check("aar0_irq2", WIDTH'(upd_irq), WIDTH'(1));
    stop = 1'b1; cyc(); stop = 1'b0;
    check("aar0_pend", WIDTH'(busy), WIDTH'(1));
    cyc();
    check("aar0_stopped", WIDTH'(PWM_EN), WIDTH'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_sched.md
Name: pwm_cfg_sched

Overview:
- Configuration and sequencing controller for the PWM period counter and its compare stage.
- Holds host-written shadow copies of period (AAR), compare (CCR), mode and repetition count (RCR).
- Commits shadows to the active outputs only at counter period boundaries, so a period never runs with a half-updated configuration.
- Drives the counter's PWM_EN with start/graceful-stop sequencing and raises an update interrupt pulse. Counter and controller share clk.

Parameters:
WIDTH, 64, width of AAR/CCR/cnt_val and config data bus
RCR_W, 8, width of repetition counter register

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  synchronous reset, active-high
cfg_we  in  1  config write strobe, one write per cycle
cfg_addr  in  2  0=AAR, 1=CCR, 2=CTRL (bit0 mode), 3=RCR
cfg_wdata  in  WIDTH  write data (CTRL uses bit0, RCR uses [RCR_W-1:0])
cfg_rdata  out  WIDTH  combinational readback of shadow register at cfg_addr, zero-extended
start  in  1  request to start generation
stop  in  1  request graceful stop
cnt_val  in  WIDTH  current counter value
PWM_EN  out  1  counter enable
mode  out  1  active mode, 0 up / 1 up-down
AAR  out  WIDTH  active period
CCR  out  WIDTH  active compare
upd_irq  out  1  one-cycle pulse when shadows committed in RUN
busy  out  1  high in RUN or STOP_PEND

Behaviour:
- Reset (rst=1 at edge): all shadows, active regs, rep counter and prev_cnt = 0; state = IDLE; PWM_EN = 0, mode = 0, AAR = 0, CCR = 0, upd_irq = 0, busy = 0. Reset overrides every other input in any state.
- Writes: on cfg_we, the shadow at cfg_addr is loaded at that edge. Active outputs are never written directly.
- Period boundary (pb), combinational, valid only while PWM_EN = 1:
  - mode = 0: pb = (cnt_val >= AAR).
  - mode = 1: pb = (cnt_val == 0) && (prev_cnt != 0).
  - prev_cnt is cnt_val registered every cycle and is cleared whenever PWM_EN = 0.
- Repetition: rep_cnt counts pb events. An update event (ue) is pb && (rep_cnt == RCR active copy).
  - On ue, rep_cnt <= 0; on pb without ue, rep_cnt increments.
  - RCR = 0 gives an update every period.
- Commit on ue (in RUN): at the same edge, active AAR/CCR/mode/RCR <= shadows, and upd_irq = 1 for the following cycle. The counter therefore sees the new values from the first count of the next period.
- Write and ue in the same cycle: active takes the pre-write shadow value; the new write lands in the shadow and commits at the next ue.
- FSM:
  - IDLE: PWM_EN = 0. On start && !stop: force commit of all shadows (no upd_irq), clear rep_cnt, go to RUN; PWM_EN = 1 from the next cycle. start && stop together: stay IDLE. stop alone: ignored.
  - RUN: PWM_EN = 1, busy = 1; commits on ue. On stop: go to STOP_PEND. start is ignored.
  - STOP_PEND: PWM_EN = 1, commits still occur on ue. At the first pb (raw, ignoring the repetition count): go to IDLE; PWM_EN = 0 at that edge. start is ignored.
- Re-entering RUN always restarts with the counter from 0, because the counter clears while PWM_EN = 0.
- Widths: rep_cnt is RCR_W bits and is never compared wider than RCR_W. AAR = 0 in up mode gives pb every cycle.

Test Plan:
- Reset/start: write AAR=4, CCR=2, mode=0, RCR=0; pulse start → PWM_EN rises the next cycle with AAR=4, CCR=2; cnt_val runs 0..4,0; upd_irq pulses the cycle after each cnt_val=4; all outputs are 0 after rst.
- Shadowing: in RUN with AAR=4, write AAR=9 when cnt_val=1 → AAR output stays 4 until the edge at cnt_val=4, then becomes 9; the next period counts 0..9. Write landing in the ue cycle → commits one period later.
- Repetition: RCR=2, AAR=3 → upd_irq every 3rd period (every 12 cycles); a shadow AAR change takes effect only at that boundary.
- Up-down: mode=1, AAR=3 → counter 0,1,2,3,2,1,0,1,...; pb only at the return to 0, never at the initial 0 after start.
- Graceful stop: stop at cnt_val=2, AAR=5, RCR=3 → PWM_EN stays 1 through cnt_val=5, drops at that boundary; busy drops with it; start && stop together in IDLE → no start.
- Reset mid-run: rst=1 at cnt_val=3 in STOP_PEND → next cycle IDLE, PWM_EN=0, cfg_rdata for every address = 0.
